// File: rtl/data_path_hs.sv
`default_nettype none
// ============================================================================
// Module      : data_path_hs
// Description : Multicycle RISC-V datapath with a valid/grant/response memory
//               handshake, parametrised register file, ALU flags, byte-lane
//               store alignment and sign/zero-extended loads.
//               Optional feature macro: MISALIGN_TRAP_EN (adds 'misaligned').
// Revision    : 1.0 - initial release
// ============================================================================
module data_path_hs #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        imm_src,
  input  logic [3:0]        alu_control,
  input  logic [1:0]        result_src,
  input  logic [1:0]        alu_src_a,
  input  logic [1:0]        alu_src_b,
  input  logic              reg_write,
  input  logic              pc_write,
  input  logic              adr_src,
  input  logic              mem_start,
  input  logic              mem_fetch,
  input  logic              mem_we,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy,
  output logic              mem_done,
  output logic              zero,
  output logic              cout,
  output logic              overflow,
  output logic              sign,
`ifdef MISALIGN_TRAP_EN
  output logic              misaligned,
`endif
  output logic [31:0]       instr
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

  mem_state_e state_q, state_d;

  logic [XLEN-1:0] pc_q, old_pc_q, a_q, b_q, alu_out_q, data_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [XLEN-1:0] adr_q, wdata_q;
  logic [NB-1:0]   be_q;
  logic            fetch_q, we_q, done_q;
  logic [2:0]      f3_q;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm_ext, w_rd1, w_rd2, w_src_a, w_src_b, w_b_op;
  logic [XLEN:0]   w_sum;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_alu_result, w_result, w_adr, w_ld_shift, w_ld_ext;
  logic            w_is_sub, w_cout, w_ovf;
  logic [RW-1:0]   w_rs1, w_rs2, w_rd;
  logic [NB-1:0]   w_size_mask, w_be;
  logic [XLEN-1:0] w_wdata;
  logic            w_start_acc, w_done_d, w_rsp_take;
  logic [LB-1:0]   w_off;
`ifdef MISALIGN_TRAP_EN
  logic            mis_q, w_mis_d, w_misaligned;
  logic [LB-1:0]   w_align_mask;
`endif

  assign w_rs1 = instr_q[15 +: RW];
  assign w_rs2 = instr_q[20 +: RW];
  assign w_rd  = instr_q[7 +: RW];
  assign w_rd1 = (w_rs1 == '0) ? '0 : rf_q[w_rs1];
  assign w_rd2 = (w_rs2 == '0) ? '0 : rf_q[w_rs2];

  // Immediate decode (I, S, B, J, U) sign-extended to XLEN
  always_comb begin
    w_imm32 = '0;
    case (imm_src)
      3'd0: w_imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      3'd1: w_imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      3'd2: w_imm32 = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      3'd3: w_imm32 = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      3'd4: w_imm32 = {instr_q[31:12], 12'b0};
      default: w_imm32 = '0;
    endcase
    w_imm_ext = XLEN'($signed(w_imm32));
  end

  // ALU operand muxes, operation and flags
  always_comb begin
    case (alu_src_a)
      2'd0:    w_src_a = pc_q;
      2'd1:    w_src_a = old_pc_q;
      2'd2:    w_src_a = a_q;
      default: w_src_a = '0;
    endcase
    case (alu_src_b)
      2'd0:    w_src_b = b_q;
      2'd1:    w_src_b = w_imm_ext;
      2'd2:    w_src_b = XLEN'(4);
      default: w_src_b = '0;
    endcase
    w_is_sub     = (alu_control == 4'd1);
    w_b_op       = w_is_sub ? ~w_src_b : w_src_b;
    w_sum        = {1'b0, w_src_a} + {1'b0, w_b_op} + {{XLEN{1'b0}}, w_is_sub};
    w_shamt      = w_src_b[SW-1:0];
    w_alu_result = '0;
    w_cout       = 1'b0;
    w_ovf        = 1'b0;
    case (alu_control)
      4'd0, 4'd1: begin
        w_alu_result = w_sum[XLEN-1:0];
        w_cout       = w_sum[XLEN];
        w_ovf        = (w_src_a[XLEN-1] == w_b_op[XLEN-1]) &&
                       (w_sum[XLEN-1] != w_src_a[XLEN-1]);
      end
      4'd2: w_alu_result = w_src_a & w_src_b;
      4'd3: w_alu_result = w_src_a | w_src_b;
      4'd4: w_alu_result = w_src_a ^ w_src_b;
      4'd5: w_alu_result = XLEN'($signed(w_src_a) < $signed(w_src_b));
      4'd6: w_alu_result = XLEN'(w_src_a < w_src_b);
      4'd7: w_alu_result = w_src_a << w_shamt;
      4'd8: w_alu_result = w_src_a >> w_shamt;
      4'd9: w_alu_result = $signed(w_src_a) >>> w_shamt;
      default: w_alu_result = '0;
    endcase
  end

  assign zero     = (w_alu_result == '0);
  assign sign     = w_alu_result[XLEN-1];
  assign cout     = w_cout;
  assign overflow = w_ovf;

  // Result bus and memory address select
  always_comb begin
    case (result_src)
      2'd0:    w_result = alu_out_q;
      2'd1:    w_result = data_q;
      2'd2:    w_result = w_alu_result;
      default: w_result = w_imm_ext;
    endcase
    w_adr = adr_src ? w_result : pc_q;
  end

  // Store lane placement from the current address, funct3 and B
  always_comb begin
    w_off = w_adr[LB-1:0];
    case (instr_q[13:12])
      2'd0:    w_size_mask = NB'(1);
      2'd1:    w_size_mask = NB'(3);
      2'd2:    w_size_mask = NB'(15);
      default: w_size_mask = '1;
    endcase
    w_be    = mem_fetch ? '1 : (w_size_mask << w_off);
    w_wdata = b_q << {w_off, 3'b000};
`ifdef MISALIGN_TRAP_EN
    case (instr_q[13:12])
      2'd0:    w_align_mask = LB'(0);
      2'd1:    w_align_mask = LB'(1);
      2'd2:    w_align_mask = LB'(3);
      default: w_align_mask = LB'(7);
    endcase
    if (mem_fetch) w_align_mask = LB'(3);
    w_misaligned = |(w_off & w_align_mask);
`endif
  end

  // Load data: select addressed lane, then sign/zero-extend per funct3
  always_comb begin
    w_ld_shift = mem_rdata >> {adr_q[LB-1:0], 3'b000};
    case (f3_q)
      3'd0:    w_ld_ext = XLEN'($signed(w_ld_shift[7:0]));
      3'd1:    w_ld_ext = XLEN'($signed(w_ld_shift[15:0]));
      3'd2:    w_ld_ext = XLEN'($signed(w_ld_shift[31:0]));
      3'd4:    w_ld_ext = XLEN'(w_ld_shift[7:0]);
      3'd5:    w_ld_ext = XLEN'(w_ld_shift[15:0]);
      3'd6:    w_ld_ext = XLEN'(w_ld_shift[31:0]);
      default: w_ld_ext = w_ld_shift;
    endcase
  end

  // Register file: synchronous write, x0 writes discarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (reg_write && (w_rd != '0)) begin
      rf_q[w_rd] <= w_result;
    end
  end

  // Architectural datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      old_pc_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      data_q    <= '0;
      instr_q   <= '0;
    end else begin
      a_q       <= w_rd1;
      b_q       <= w_rd2;
      alu_out_q <= w_alu_result;
      if (pc_write) pc_q <= w_result;
      if (w_rsp_take) begin
        if (fetch_q) begin
          instr_q  <= mem_rdata[31:0];
          old_pc_q <= pc_q;
        end else begin
          data_q   <= w_ld_ext;
        end
      end
    end
  end

  // Memory FSM next state and single-cycle control strobes
  always_comb begin
    state_d     = state_q;
    w_start_acc = 1'b0;
    w_done_d    = 1'b0;
    w_rsp_take  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    w_mis_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_start) begin
`ifdef MISALIGN_TRAP_EN
          if (w_misaligned) begin
            w_mis_d  = 1'b1;
            w_done_d = 1'b1;
          end else
`endif
          begin
            w_start_acc = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            state_d  = S_IDLE;
            w_done_d = 1'b1;
          end else begin
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_d    = S_IDLE;
          w_done_d   = 1'b1;
          w_rsp_take = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory FSM state and request latches held stable through REQ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      fetch_q <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      done_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= w_done_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= w_mis_d;
`endif
      if (w_start_acc) begin
        adr_q   <= w_adr;
        wdata_q <= w_wdata;
        be_q    <= w_be;
        fetch_q <= mem_fetch;
        we_q    <= mem_we;
        f3_q    <= instr_q[14:12];
      end
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_wr    = mem_req & we_q;
  assign mem_addr  = {adr_q[XLEN-1:LB], {LB{1'b0}}};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_done  = done_q;
  assign instr     = instr_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_path_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_path_hs
// Description : Directed self-checking bench for data_path_hs (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_path_hs;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  imm_src = '0;
  logic [3:0]  alu_control = '0;
  logic [1:0]  result_src = '0;
  logic [1:0]  alu_src_a = '0;
  logic [1:0]  alu_src_b = '0;
  logic        reg_write = 1'b0;
  logic        pc_write = 1'b0;
  logic        adr_src = 1'b0;
  logic        mem_start = 1'b0;
  logic        mem_fetch = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, mem_done, zero, cout, overflow, sign;
  logic [31:0] instr;

  int checks = 0;
  int failures = 0;

  data_path_hs #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imm_src(imm_src), .alu_control(alu_control),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .pc_write(pc_write), .adr_src(adr_src),
    .mem_start(mem_start), .mem_fetch(mem_fetch), .mem_we(mem_we),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .mem_done(mem_done), .zero(zero),
    .cout(cout), .overflow(overflow), .sign(sign), .instr(instr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch: start at pc, grant next cycle, respond the cycle after
  task automatic do_fetch(input logic [31:0] word);
    adr_src = 1'b0; mem_start = 1'b1; mem_fetch = 1'b1;
    step();
    mem_start = 1'b0; mem_fetch = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = word;
    step();
    mem_rvalid = 1'b0;
  endtask

  task automatic do_load(input logic sel, input logic [31:0] word);
    adr_src = sel; mem_start = 1'b1;
    step();
    mem_start = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = word;
    step();
    mem_rvalid = 1'b0;
  endtask

  task automatic write_rd_from_data();
    result_src = 2'd1; reg_write = 1'b1;
    step();
    reg_write = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    checks++; if (dut.pc_q !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected %h", dut.pc_q, 32'h0); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL reset_mem_done: got %b expected 0", mem_done); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if ({zero, cout, overflow, sign} !== 4'b1000) begin failures++; $display("FAIL reset_flags: got %b expected 1000", {zero, cout, overflow, sign}); end
  endtask

  task automatic test_fetch();
    alu_src_a = 2'd0; alu_src_b = 2'd2; alu_control = 4'd0; result_src = 2'd2; pc_write = 1'b1;
    repeat (4) step();
    pc_write = 1'b0; result_src = 2'd0;
    checks++; if (dut.pc_q !== 32'h10) begin failures++; $display("FAIL fetch_pc_setup: got %h expected 10", dut.pc_q); end
    adr_src = 1'b0; mem_start = 1'b1; mem_fetch = 1'b1;
    step();
    mem_start = 1'b0; mem_fetch = 1'b0;
    checks++; if ({mem_req, busy, mem_wr} !== 3'b110) begin failures++; $display("FAIL fetch_req: got %b expected 110", {mem_req, busy, mem_wr}); end
    checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL fetch_addr: got %h expected 10", mem_addr); end
    step();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_req_hold: got %b expected 1", mem_req); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if ({mem_req, busy, mem_done} !== 3'b010) begin failures++; $display("FAIL fetch_resp_wait: got %b expected 010", {mem_req, busy, mem_done}); end
    mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    step();
    mem_rvalid = 1'b0;
    checks++; if (instr !== 32'h00500093) begin failures++; $display("FAIL fetch_instr: got %h expected 00500093", instr); end
    checks++; if (dut.old_pc_q !== 32'h10) begin failures++; $display("FAIL fetch_old_pc: got %h expected 10", dut.old_pc_q); end
    checks++; if ({mem_done, busy} !== 2'b10) begin failures++; $display("FAIL fetch_done: got %b expected 10", {mem_done, busy}); end
    step();
    checks++; if ({mem_done, busy} !== 2'b00) begin failures++; $display("FAIL fetch_done_single: got %b expected 00", {mem_done, busy}); end
  endtask

  task automatic test_alu_flags();
    do_fetch(32'h0020A083);          // rd=x1 rs1=x1 rs2=x2 funct3=LW
    do_load(1'b0, 32'h7FFFFFFF);
    write_rd_from_data();
    do_fetch(32'h0020A103);          // rd=x2 rs1=x1 rs2=x2 funct3=LW
    do_load(1'b0, 32'h00000001);
    write_rd_from_data();
    alu_src_a = 2'd2; alu_src_b = 2'd0; alu_control = 4'd0;
    #1;
    checks++; if ({zero, cout, overflow, sign} !== 4'b0011) begin failures++; $display("FAIL add_ovf_flags: got %b expected 0011", {zero, cout, overflow, sign}); end
    alu_control = 4'd5;              // SLT 0x7FFFFFFF < 1 is false
    #1;
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL slt_zero: got %b expected 1", zero); end
    alu_control = 4'd9;              // SRA 0x7FFFFFFF by 1 -> 0x3FFFFFFF
    #1;
    checks++; if ({zero, sign} !== 2'b00) begin failures++; $display("FAIL sra_flags: got %b expected 00", {zero, sign}); end
    do_fetch(32'h00212103);          // rd=x2 rs1=x2 rs2=x2 funct3=LW
    do_load(1'b0, 32'h00000005);
    write_rd_from_data();
    alu_control = 4'd1;
    #1;
    checks++; if ({zero, cout, overflow, sign} !== 4'b1100) begin failures++; $display("FAIL sub_eq_flags: got %b expected 1100", {zero, cout, overflow, sign}); end
    alu_control = 4'd0; alu_src_a = 2'd0;
  endtask

  task automatic test_load_ext();
    do_fetch(32'h00200003);          // lb x0, 2(x0)
    imm_src = 3'd0; result_src = 2'd3;
    do_load(1'b1, 32'h00800000);
    checks++; if (dut.data_q !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sign: got %h expected FFFFFF80", dut.data_q); end
    do_fetch(32'h00204003);          // lbu x0, 2(x0)
    result_src = 2'd3;
    do_load(1'b1, 32'h00800000);
    checks++; if (dut.data_q !== 32'h00000080) begin failures++; $display("FAIL lbu_zero: got %h expected 00000080", dut.data_q); end
    do_fetch(32'h00201003);          // lh x0, 2(x0)
    result_src = 2'd3;
    do_load(1'b1, 32'h80000000);
    checks++; if (dut.data_q !== 32'hFFFF8000) begin failures++; $display("FAIL lh_sign: got %h expected FFFF8000", dut.data_q); end
    result_src = 2'd0;
  endtask

  task automatic test_store();
    do_fetch(32'h0020A103);          // rd=x2, funct3=LW
    do_load(1'b0, 32'h000000AB);
    write_rd_from_data();
    do_fetch(32'h102001A3);          // sb x2, 0x103(x0)
    step();
    imm_src = 3'd1; result_src = 2'd3; adr_src = 1'b1; mem_we = 1'b1; mem_start = 1'b1;
    step();
    mem_start = 1'b0; mem_we = 1'b0;
    checks++; if ({mem_req, mem_wr} !== 2'b11) begin failures++; $display("FAIL sb_req: got %b expected 11", {mem_req, mem_wr}); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL sb_addr: got %h expected 100", mem_addr); end
    checks++; if (mem_be !== 4'b1000) begin failures++; $display("FAIL sb_be: got %b expected 1000", mem_be); end
    checks++; if (mem_wdata !== 32'hAB000000) begin failures++; $display("FAIL sb_wdata: got %h expected AB000000", mem_wdata); end
    adr_src = 1'b0; mem_fetch = 1'b1; mem_start = 1'b1;   // must be ignored
    step();
    mem_start = 1'b0; mem_fetch = 1'b0;
    checks++; if ({mem_wr, mem_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL busy_start_ignored: got %b/%h expected 1/100", mem_wr, mem_addr); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if ({mem_done, mem_req, busy} !== 3'b100) begin failures++; $display("FAIL sb_done: got %b expected 100", {mem_done, mem_req, busy}); end
    step();
    checks++; if ({mem_done, mem_req, busy} !== 3'b000) begin failures++; $display("FAIL sb_after: got %b expected 000", {mem_done, mem_req, busy}); end
    checks++; if (dut.data_q !== 32'h000000AB) begin failures++; $display("FAIL sb_data_kept: got %h expected 000000AB", dut.data_q); end
    imm_src = 3'd0; result_src = 2'd0;
  endtask

  task automatic test_reset_mid();
    adr_src = 1'b0; mem_start = 1'b1; mem_fetch = 1'b1;
    step();
    mem_start = 1'b0; mem_fetch = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_in_resp: got %b expected 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({mem_req, busy} !== 2'b00) begin failures++; $display("FAIL mid_async_drop: got %b expected 00", {mem_req, busy}); end
    step();
    reset = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 1'b0;
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL mid_rvalid_ignored: got %h expected 0", instr); end
    checks++; if ({mem_done, mem_req, busy} !== 3'b000) begin failures++; $display("FAIL mid_idle: got %b expected 000", {mem_done, mem_req, busy}); end
    checks++; if (dut.pc_q !== 32'h0) begin failures++; $display("FAIL mid_pc: got %h expected 0", dut.pc_q); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_alu_flags();
    test_load_ext();
    test_store();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_path_hs.md
Name: data_path_hs

Overview:
- Parametrised successor to the multicycle datapath; adds a valid/grant/response memory handshake in place of the fixed-latency read port.
- Adds a generic register file depth and real ALU flags (replacing tied-off cout/overflow/sign).
- Adds byte-lane store alignment and sign/zero-extended loads.
- Sits between the multicycle controller and a shared instruction/data memory port. The controller stalls on busy and advances on mem_done.

Parameters:
XLEN, 32, datapath width (32 or 64)
NREGS, 32, architectural registers (16 for RV32E; register index uses log2(NREGS) LSBs)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imm_src  in  3  immediate format select, same encoding as extend
alu_control  in  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; others give result 0
result_src  in  2  0 alu_out, 1 data, 2 alu_result, 3 imm_ext
alu_src_a  in  2  0 pc, 1 old_pc, 2 A
alu_src_b  in  2  0 B, 1 imm_ext, 2 constant 4
reg_write, pc_write  in  1  write enables
adr_src  in  1  0 pc, 1 result
mem_start  in  1  pulse: begin one memory transaction at adr
mem_fetch  in  1  with mem_start: transaction is an instruction fetch
mem_we  in  1  with mem_start: transaction is a store
mem_req  out  1  request valid
mem_wr  out  1  request is a write
mem_addr  out  XLEN  word-aligned address
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-aligned store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data
busy, mem_done  out  1  transaction in flight / one-cycle completion pulse
zero, cout, overflow, sign  out  1  combinational flags of the current ALU op
instr  out  32  instruction register

Behaviour:
- Reset: pc=RESET_PC. instr, old_pc, A, B, alu_out, data and all registers = 0. FSM=IDLE. mem_req, busy, mem_done = 0.
- x0 reads 0; writes to x0 are dropped. Register file has synchronous write and combinational read. A and B capture rd1/rd2 every cycle.
- ALU:
  - ADD/SUB: cout = carry out of bit XLEN-1; SUB computes A + ~B + 1. Overflow is signed overflow for ADD/SUB only, 0 otherwise.
  - sign = result MSB; zero = (result == 0).
  - Shifts use the low log2(XLEN) bits of B.
- alu_out registers alu_result every cycle. pc loads result when pc_write=1.
- Memory FSM:
  - IDLE: on mem_start, latch adr, kind and funct3=instr[14:12]; go to REQ. busy rises in the same cycle.
  - REQ: hold mem_req=1 with stable outputs until mem_gnt. For a write, then go to IDLE and pulse mem_done. For a read, go to RESP.
  - RESP: wait for mem_rvalid, then go to IDLE and pulse mem_done.
  - mem_start while busy is ignored.
  - Minimum latency: write 2 cycles (start → done); read 3 cycles.
- On a read response:
  - Fetch: instr <= mem_rdata[31:0]; old_pc <= pc.
  - Load: data <= the byte selected by adr[1:0] (adr[2:0] when XLEN=64), extended per funct3: 0 LB sign, 1 LH sign, 2 LW sign, 4 LBU zero, 5 LHU zero, 6 LWU zero.
- Stores:
  - funct3 0 SB, 1 SH, 2 SW, 3 SD (XLEN=64 only).
  - mem_be has the addressed bytes set; mem_wdata is B shifted to those lanes.
- mem_rvalid outside RESP is ignored. mem_gnt outside REQ is ignored.
- reset asserted mid-transaction: FSM returns to IDLE immediately and mem_req drops asynchronously.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output misaligned (1 bit). On mem_start whose adr is not naturally aligned for the access size, no request is issued, misaligned pulses for one cycle, mem_done pulses, and data/instr are unchanged.
- Undefined: no port; low address bits select lanes and any bytes past the word boundary are dropped.

Test Plan:
- Reset released, pc_write=0 → pc=RESET_PC; mem_req=0; instr=0; flags all 0 for ADD 0+0 except zero=1.
- Fetch, adr=0x10, gnt after 2 cycles, rvalid 1 cycle later with 0x00500093 → instr=0x00500093, old_pc=0x10, single mem_done pulse, busy low afterwards.
- SB with B=0x000000AB at adr=0x103 → mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xAB000000, mem_done the cycle after gnt.
- LB at adr=0x2 with rdata=0x00800000 → data=0xFFFFFF80; LBU with the same inputs → data=0x00000080.
- ADD 0x7FFFFFFF+1 → overflow=1, sign=1, cout=0; SUB 5-5 → zero=1, cout=1.
- reset asserted while in RESP, then released → mem_req=0, busy=0; a later rvalid is ignored and instr is unchanged.
